i2c_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one I2C_master between N_REQ requesters.
- Each requester presents a complete transaction (addr, data, rw) with a level request.
- The arbiter picks one requester, drives the master's send/addr/data/rw, and tracks the master's busy.
- On completion or timeout it returns a one-cycle done/err pulse to the winner.
- Sits between user logic (sensor/config engines) and I2C_master inside top_level1-style wrappers.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_arbiter_if.sv | 44 ++++
 rtl/rr_pick.sv | 39 +++
 rtl/i2c_arbiter.sv | 153 +++++++++++++++
 tb/tb_i2c_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master and the logic that feeds it:
// bus field widths, the arbiter FSM state encodings and the latched
// transaction record.
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One complete transaction as handed to the I2C master.
    typedef struct packed {
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] data;
        logic                  rw;
    } i2c_txn_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_arbiter_if
// Bundle between N_REQ requesters, the arbiter and one I2C master.
//   req/req_addr/req_data/req_rw : requester transactions (flattened, index i
//                                  occupies bits [W*i+W-1:W*i])
//   grant/done/err               : arbiter replies to the requesters
//   m_send/m_addr/m_data/m_rw    : arbiter drive into the I2C master
//   m_busy                       : I2C master activity indication
// Modports:
//   master : the arbiter side (owns the I2C master)
//   slave  : the environment side (requesters plus the I2C master)
// ---------------------------------------------------------------------------
interface i2c_arbiter_if
    import i2c_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]            req;
    logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
    logic [I2C_DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]            req_rw;

    logic [N_REQ-1:0]            grant;
    logic [N_REQ-1:0]            done;
    logic                        err;

    logic                        m_send;
    logic [I2C_ADDR_W-1:0]       m_addr;
    logic [I2C_DATA_W-1:0]       m_data;
    logic                        m_rw;
    logic                        m_busy;

    modport master (
        input  req, req_addr, req_data, req_rw, m_busy,
        output grant, done, err, m_send, m_addr, m_data, m_rw
    );

    modport slave (
        output req, req_addr, req_data, req_rw, m_busy,
        input  grant, done, err, m_send, m_addr, m_data, m_rw
    );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first set request found
// scanning cyclically upward from ptr_i.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot winner (all zero when nothing requested)
//   idx_o   : binary index of the winner
//   valid_o : at least one request was set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int scan;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        scan    = 0;
        for (int off = 0; off < N; off++) begin
            scan = (int'(ptr_i) + off) % N;
            if (!valid_o && req_i[scan]) begin
                valid_o       = 1'b1;
                grant_o[scan] = 1'b1;
                idx_o         = PW'(scan);
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
// Round-robin arbiter/sequencer sharing one I2C master between N_REQ
// requesters. A winner's addr/data/rw are latched onto the master port,
// m_send is held until the master reports busy (or a timeout expires), and
// a one-cycle done (plus err on timeout) is returned to the winner.
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : i2c_arbiter_if master modport (requesters + I2C master)
// ---------------------------------------------------------------------------
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TW             = 11
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    i2c_arbiter_if.master bus
);

    localparam int            PW           = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_SAT  = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] LAST_IDX     = PW'(N_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic             send_q, send_d;
    i2c_txn_t         txn_q, txn_d;
    logic [TW-1:0]    cnt_q, cnt_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    i2c_txn_t         pick_txn;
    int               pick_sel;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Candidate transaction of the current round-robin winner.
    always_comb begin
        pick_sel      = int'(pick_idx);
        pick_txn.addr = bus.req_addr[pick_sel*I2C_ADDR_W +: I2C_ADDR_W];
        pick_txn.data = bus.req_data[pick_sel*I2C_DATA_W +: I2C_DATA_W];
        pick_txn.rw   = bus.req_rw[pick_sel];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        done_d   = done_q;
        err_d    = err_q;
        send_d   = send_q;
        txn_d    = txn_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Stray master activity blocks a new grant.
                if (!bus.m_busy && pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    txn_d   = pick_txn;
                    send_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // cnt_q counts completed ISSUE cycles; when this cycle would
                // bring it to TIMEOUT_CYCLES, give up and saturate.
                if (bus.m_busy) begin
                    send_d  = 1'b0;
                    state_d = ST_BUSY;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    send_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    cnt_d   = TIMEOUT_SAT;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!bus.m_busy) begin
                    done_d  = grant_q;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d  = '0;
                done_d   = '0;
                err_d    = 1'b0;
                rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            send_q   <= 1'b0;
            txn_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            send_q   <= send_d;
            txn_q    <= txn_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.m_send = send_q;
    assign bus.m_addr = txn_q.addr;
    assign bus.m_data = txn_q.data;
    assign bus.m_rw   = txn_q.rw;

endmodule

// File: tb/tb_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_arbiter
// Directed bench for i2c_arbiter (N_REQ=4, TIMEOUT_CYCLES=16). Inputs are
// driven and outputs sampled on the falling clock edge; the bench itself
// plays the I2C master by driving m_busy.
// ---------------------------------------------------------------------------
module tb_i2c_arbiter;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [6:0] exp_addr [N] = '{7'h3B, 7'h11, 7'h22, 7'h33};
    logic [7:0] exp_data [N] = '{8'h7D, 8'hA1, 8'hA2, 8'hA3};
    logic       exp_rw   [N] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    i2c_arbiter_if #(.N_REQ(N)) bus ();

    i2c_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (16),
        .TW             (5)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    // Pulse reset with all requests dropped; ends on a falling edge.
    task automatic do_reset();
        reset      = 1'b1;
        bus.req    = '0;
        bus.m_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for m_send, records the grant, then acts as a master
    // that is busy for one cycle. Returns on the falling edge where done is
    // expected to be visible.
    task automatic serve_one(output logic [N-1:0] g, output logic [6:0] a,
                             output logic [7:0] dat, output logic rw,
                             output logic [N-1:0] d, output int waits,
                             output bit ok);
        ok    = 1'b0;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.m_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            waits++;
        end
        g   = bus.grant;
        a   = bus.m_addr;
        dat = bus.m_data;
        rw  = bus.m_rw;
        d   = '0;
        if (ok) begin
            bus.m_busy = 1'b1;
            @(negedge clk);
            bus.m_busy = 1'b0;
            @(negedge clk);
            d = bus.done;
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.req    = '0;
        bus.m_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_grant: got %b expected 0000", bus.grant);
        end
        tests_run++;
        if (bus.m_send !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_send: got %b expected 0", bus.m_send);
        end
        tests_run++;
        if ({bus.done, bus.err} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done_err: got %b expected 00000", {bus.done, bus.err});
        end
        tests_run++;
        if ({bus.m_addr, bus.m_data, bus.m_rw} !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_master_fields: got %h expected 0000",
                     {bus.m_addr, bus.m_data, bus.m_rw});
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_req_grant: got %b expected 0000", bus.grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        tests_run++;
        if ({bus.grant, bus.m_send} !== 5'b0001_1) begin
            tests_failed++;
            $display("[TB] FAIL single_grant_send: got %b expected 00011", {bus.grant, bus.m_send});
        end
        tests_run++;
        if ({bus.m_addr, bus.m_data, bus.m_rw} !== {7'h3B, 8'h7D, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL single_fields: got %h expected %h",
                     {bus.m_addr, bus.m_data, bus.m_rw}, {7'h3B, 8'h7D, 1'b0});
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.m_send !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_send_held: got %b expected 1", bus.m_send);
        end
        bus.m_busy = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.grant, bus.m_send} !== 5'b0001_0) begin
            tests_failed++;
            $display("[TB] FAIL single_send_drop: got %b expected 00010", {bus.grant, bus.m_send});
        end
        repeat (19) @(negedge clk);
        tests_run++;
        if (bus.done !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_no_early_done: got %b expected 0000", bus.done);
        end
        bus.m_busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.done, bus.err} !== 5'b0001_0) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got %b expected 00010", {bus.done, bus.err});
        end
        bus.req = '0;
        @(negedge clk);
        tests_run++;
        if ({bus.done, bus.grant} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL single_after_done: got %b expected 00000000", {bus.done, bus.grant});
        end
        tests_run++;
        if (bus.m_addr !== 7'h3B) begin
            tests_failed++;
            $display("[TB] FAIL single_addr_hold: got %h expected 3b", bus.m_addr);
        end
    endtask

    task automatic test_contention();
        int            order [6] = '{0, 1, 3, 0, 1, 3};
        logic [N-1:0]  g, d, eg;
        logic [6:0]    a;
        logic [7:0]    dat;
        logic          rw;
        int            waits;
        bit            ok;
        do_reset();
        bus.req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            serve_one(g, a, dat, rw, d, waits, ok);
            eg = '0;
            eg[order[k]] = 1'b1;
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("[TB] FAIL contention_send_timeout[%0d]: got no m_send expected m_send", k);
            end
            tests_run++;
            if (g !== eg) begin
                tests_failed++;
                $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", k, g, eg);
            end
            tests_run++;
            if ({a, dat, rw} !== {exp_addr[order[k]], exp_data[order[k]], exp_rw[order[k]]}) begin
                tests_failed++;
                $display("[TB] FAIL contention_fields[%0d]: got %h expected %h", k, {a, dat, rw},
                         {exp_addr[order[k]], exp_data[order[k]], exp_rw[order[k]]});
            end
            tests_run++;
            if (d !== eg) begin
                tests_failed++;
                $display("[TB] FAIL contention_done[%0d]: got %b expected %b", k, d, eg);
            end
            if (k > 0) begin
                tests_run++;
                if (waits != 2) begin
                    tests_failed++;
                    $display("[TB] FAIL contention_gap[%0d]: got %0d expected 2", k, waits);
                end
            end
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int            hi;
        logic [N-1:0]  g, d;
        logic [6:0]    a;
        logic [7:0]    dat;
        logic          rw;
        int            waits;
        bit            ok;
        do_reset();
        bus.req = 4'b0100;
        @(negedge clk);
        hi = 0;
        while (bus.m_send === 1'b1 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        tests_run++;
        if (hi != 16) begin
            tests_failed++;
            $display("[TB] FAIL timeout_send_cycles: got %0d expected 16", hi);
        end
        tests_run++;
        if ({bus.done, bus.err} !== 5'b0100_1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_done_err: got %b expected 01001", {bus.done, bus.err});
        end
        bus.req = 4'b1100;
        @(negedge clk);
        tests_run++;
        if ({bus.done, bus.err} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_pulse_width: got %b expected 00000", {bus.done, bus.err});
        end
        serve_one(g, a, dat, rw, d, waits, ok);
        tests_run++;
        if (!ok || g !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_ptr_advance: got ok=%0d grant=%b expected ok=1 grant=1000", ok, g);
        end
        tests_run++;
        if ({d, bus.err} !== 5'b1000_0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_next_done: got %b expected 10000", {d, bus.err});
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stray_busy();
        logic [N-1:0]  g, d;
        logic [6:0]    a;
        logic [7:0]    dat;
        logic          rw;
        int            waits;
        bit            ok;
        do_reset();
        bus.m_busy = 1'b1;
        bus.req    = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.grant, bus.m_send} !== 5'b0) begin
                tests_failed++;
                $display("[TB] FAIL stray_no_grant[%0d]: got %b expected 00000", i, {bus.grant, bus.m_send});
            end
        end
        bus.m_busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.grant, bus.m_send} !== 5'b0100_1) begin
            tests_failed++;
            $display("[TB] FAIL stray_grant_after: got %b expected 01001", {bus.grant, bus.m_send});
        end
        serve_one(g, a, dat, rw, d, waits, ok);
        tests_run++;
        if (!ok || d !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL stray_done: got ok=%0d done=%b expected ok=1 done=0100", ok, d);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        logic [N-1:0]  g, d;
        logic [6:0]    a;
        logic [7:0]    dat;
        logic          rw;
        int            waits;
        bit            ok;
        do_reset();
        bus.req = 4'b0011;
        serve_one(g, a, dat, rw, d, waits, ok);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.grant, bus.m_send} !== 5'b0010_1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_second_grant: got %b expected 00101", {bus.grant, bus.m_send});
        end
        bus.m_busy = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.grant, bus.m_send, bus.done, bus.err} !== 10'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async_clear: got %b expected 0000000000",
                     {bus.grant, bus.m_send, bus.done, bus.err});
        end
        bus.m_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.grant, bus.m_send} !== 5'b0001_1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_restart_ptr: got %b expected 00011", {bus.grant, bus.m_send});
        end
        serve_one(g, a, dat, rw, d, waits, ok);
        tests_run++;
        if (!ok || d !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done: got ok=%0d done=%b expected ok=1 done=0001", ok, d);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_req();
        do_reset();
        bus.req = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL drop_grant: got %b expected 0100", bus.grant);
        end
        bus.m_busy = 1'b1;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        bus.m_busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.done, bus.err} !== 5'b0100_0) begin
            tests_failed++;
            $display("[TB] FAIL drop_done: got %b expected 01000", {bus.done, bus.err});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.grant, bus.m_send} !== 5'b0) begin
                tests_failed++;
                $display("[TB] FAIL drop_no_regrant[%0d]: got %b expected 00000", i, {bus.grant, bus.m_send});
            end
        end
    endtask

    initial begin
        bus.req    = '0;
        bus.m_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*7 +: 7] = exp_addr[i];
            bus.req_data[i*8 +: 8] = exp_data[i];
            bus.req_rw[i]          = exp_rw[i];
        end
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_stray_busy();
        test_reset_mid_busy();
        test_drop_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
